obi_arbiter_2_to_1: RTL

//   Two-master OBI arbiter: merges instruction-fetch (m0) and data (m1) OBI ports into one
//   OBI manager port that feeds the address-decoding 1-to-2 demux. Arbitrates per request,

---
 rtl/obi_arbiter_2_to_1.sv | 136 +++++++++++++
 1 files changed

// File: rtl/obi_arbiter_2_to_1.sv
// Two-master OBI arbiter with request locking and a read-owner FIFO for response routing.
// Define OBI_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed priority to m0.
module obi_arbiter_2_to_1 #(
    parameter int unsigned OUTSTANDING = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        m0_req_i,
    output logic        m0_gnt_o,
    input  logic [31:0] m0_addr_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    input  logic        m1_req_i,
    output logic        m1_gnt_o,
    input  logic [31:0] m1_addr_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        out_req_o,
    input  logic        out_gnt_i,
    output logic [31:0] out_addr_o,
    output logic        out_we_o,
    output logic [3:0]  out_be_o,
    output logic [31:0] out_wdata_o,
    input  logic        out_rvalid_i,
    input  logic [31:0] out_rdata_i,
    output logic        busy_o
);

    localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);
    localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int unsigned DEPTH = 1 << PTR_W;

    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [DEPTH-1:0] owners;
    logic             lock_valid;
    logic             lock_sel;
    logic             last_grant;

    logic sel;
    logic tie_sel;
    logic full;
    logic empty;
    logic handshake;
    logic push;
    logic pop;
    logic head;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(OUTSTANDING - 1))
            return '0;
        else
            return p + 1'b1;
    endfunction

`ifdef OBI_ARB_ROUND_ROBIN_EN
    assign tie_sel = ~last_grant;
`else
    // Fixed priority: the grant history is still tracked but does not steer the tie.
    assign tie_sel = last_grant & 1'b0;
`endif

    always_comb begin
        sel = 1'b0;
        if (lock_valid)
            sel = lock_sel;
        else if (m0_req_i && m1_req_i)
            sel = tie_sel;
        else if (m1_req_i)
            sel = 1'b1;
    end

    assign full      = (count == CNT_W'(OUTSTANDING));
    assign empty     = (count == '0);
    assign out_req_o = (m0_req_i | m1_req_i) & ~full;
    assign handshake = out_req_o & out_gnt_i;

    assign out_addr_o  = sel ? m1_addr_i  : m0_addr_i;
    assign out_we_o    = sel ? m1_we_i    : m0_we_i;
    assign out_be_o    = sel ? m1_be_i    : m0_be_i;
    assign out_wdata_o = sel ? m1_wdata_i : m0_wdata_i;

    assign m0_gnt_o = handshake & ~sel;
    assign m1_gnt_o = handshake & sel;

    assign push = handshake & ~out_we_o;
    assign pop  = out_rvalid_i & ~empty;
    assign head = owners[rd_ptr];

    assign m0_rvalid_o = pop & ~head;
    assign m1_rvalid_o = pop & head;
    assign m0_rdata_o  = out_rdata_i;
    assign m1_rdata_o  = out_rdata_i;
    assign busy_o      = ~empty;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            owners     <= '0;
            lock_valid <= 1'b0;
            lock_sel   <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (out_req_o && !out_gnt_i) begin
                lock_valid <= 1'b1;
                lock_sel   <= sel;
            end else if (handshake) begin
                lock_valid <= 1'b0;
                last_grant <= sel;
            end

            if (push) begin
                owners[wr_ptr] <= sel;
                wr_ptr         <= ptr_next(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_next(rd_ptr);

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
